// File: rtl/config_shift_chain.sv
// -----------------------------------------------------------------------------
// config_shift_chain
//
// Per-tile configuration shift chain. Each enabled clock shifts DIN_W bits into
// a WIDTH-bit staging register. A word counter tracks how full the frame is.
// The staged frame is copied into the shadow register (data_out) only on an
// explicit commit, so the tile fabric never sees a partially shifted frame.
// The top word of the staging register is forwarded on chain_out so that tiles
// can be daisy-chained.
//
// Optional build macro: CONFIG_READBACK_EN
//   When defined, this adds a 'readback' input. A readback reloads the staging
//   register from data_out and marks the frame full, so the active
//   configuration can be shifted out on chain_out.
//
// Ports:
//   clock       rising-edge clock
//   nreset      synchronous reset, active-low
//   enable      shift one word this cycle
//   data_in     incoming configuration word (DIN_W bits)
//   commit      copy staged frame to data_out (only when full)
//   readback    (CONFIG_READBACK_EN only) reload staging reg from data_out
//   data_out    active (shadow) configuration, WIDTH bits
//   chain_out   top word of staging register, feeds the next tile
//   count       words shifted in the current frame
//   full        count == NWORDS
//   loaded      at least one successful commit since reset
//   overflow    sticky: enable seen while full
//   commit_err  sticky: commit seen while not full
// -----------------------------------------------------------------------------
module config_shift_chain #(
    parameter int WIDTH  = 146,
    parameter int DIN_W  = 1,
    localparam int NWORDS = WIDTH / DIN_W,
    localparam int CW     = $clog2(NWORDS + 1)
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             enable,
    input  logic [DIN_W-1:0] data_in,
    input  logic             commit,
`ifdef CONFIG_READBACK_EN
    input  logic             readback,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic [DIN_W-1:0] chain_out,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             loaded,
    output logic             overflow,
    output logic             commit_err
);

    localparam logic [CW-1:0] NWORDS_C = CW'(NWORDS);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [CW-1:0] ZERO_C   = CW'(0);

    // A frame must hold a whole number of words.
    if (WIDTH % DIN_W != 0) begin : g_width_check
        $error("config_shift_chain: WIDTH must be a multiple of DIN_W");
    end

    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] sr_n_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] data_out_r;
    logic [WIDTH-1:0] data_out_n_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_n_s;
    logic             full_r;
    logic             loaded_r;
    logic             loaded_n_s;
    logic             overflow_r;
    logic             overflow_n_s;
    logic             commit_err_r;
    logic             commit_err_n_s;

    // When one word spans the whole frame the shift degenerates to a load.
    if (DIN_W == WIDTH) begin : g_whole
        assign shifted_s = data_in;
    end else begin : g_part
        assign shifted_s = {sr_r[WIDTH-DIN_W-1:0], data_in};
    end

    // Next-state decode for staging register, counter, shadow and flags.
    always_comb begin
        sr_n_s         = sr_r;
        count_n_s      = count_r;
        data_out_n_s   = data_out_r;
        loaded_n_s     = loaded_r;
        overflow_n_s   = overflow_r;
        commit_err_n_s = commit_err_r;
`ifdef CONFIG_READBACK_EN
        if (readback) begin
            // Readback wins over commit and enable; no flags are touched.
            sr_n_s    = data_out_r;
            count_n_s = NWORDS_C;
        end else begin
`endif
            if (enable) begin
                sr_n_s = shifted_s;
            end else begin
                sr_n_s = sr_r;
            end

            if (commit && full_r) begin
                // Shadow takes the pre-shift frame; a simultaneous word
                // becomes the first word of the next frame.
                data_out_n_s = sr_r;
                loaded_n_s   = 1'b1;
                count_n_s    = enable ? ONE_C : ZERO_C;
            end else if (commit) begin
                commit_err_n_s = 1'b1;
                count_n_s      = enable ? (count_r + ONE_C) : count_r;
            end else if (enable && full_r) begin
                // Pass-through shift on a full frame: count saturates.
                overflow_n_s = 1'b1;
                count_n_s    = count_r;
            end else if (enable) begin
                count_n_s = count_r + ONE_C;
            end else begin
                count_n_s = count_r;
            end
`ifdef CONFIG_READBACK_EN
        end
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            sr_r         <= {WIDTH{1'b0}};
            data_out_r   <= {WIDTH{1'b0}};
            count_r      <= ZERO_C;
            full_r       <= 1'b0;
            loaded_r     <= 1'b0;
            overflow_r   <= 1'b0;
            commit_err_r <= 1'b0;
        end else begin
            sr_r         <= sr_n_s;
            data_out_r   <= data_out_n_s;
            count_r      <= count_n_s;
            full_r       <= (count_n_s == NWORDS_C);
            loaded_r     <= loaded_n_s;
            overflow_r   <= overflow_n_s;
            commit_err_r <= commit_err_n_s;
        end
    end

    assign data_out   = data_out_r;
    assign chain_out  = sr_r[WIDTH-1 -: DIN_W];
    assign count      = count_r;
    assign full       = full_r;
    assign loaded     = loaded_r;
    assign overflow   = overflow_r;
    assign commit_err = commit_err_r;

endmodule

// File: tb/tb_config_shift_chain.sv
// -----------------------------------------------------------------------------
// tb_config_shift_chain
//
// Directed bench for config_shift_chain. Two instances: an 8-bit / 2-bit-word
// chain for the protocol scenarios and a 146-bit / 1-bit-word chain for the
// full-width frame. Stimulus pushes hand-computed expected state into a queue
// tagged with the clock cycle it should be visible in; an independent monitor
// pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_config_shift_chain;

    logic         clock;
    logic         nreset;
    logic         enable;
    logic [1:0]   data_in;
    logic         commit;
    logic [7:0]   dout8;
    logic [1:0]   chain8;
    logic [2:0]   count8;
    logic         full8, loaded8, ovf8, cerr8;

    logic         en146;
    logic [0:0]   din146;
    logic         cm146;
    logic [145:0] dout146;
    logic [0:0]   chain146;
    logic [7:0]   count146;
    logic         full146, loaded146, ovf146, cerr146;

`ifdef CONFIG_READBACK_EN
    logic         readback;
    logic         readback146;
`endif

    config_shift_chain #(.WIDTH(8), .DIN_W(2)) dut8 (
        .clock(clock), .nreset(nreset), .enable(enable), .data_in(data_in),
        .commit(commit),
`ifdef CONFIG_READBACK_EN
        .readback(readback),
`endif
        .data_out(dout8), .chain_out(chain8), .count(count8), .full(full8),
        .loaded(loaded8), .overflow(ovf8), .commit_err(cerr8)
    );

    config_shift_chain #(.WIDTH(146), .DIN_W(1)) dut146 (
        .clock(clock), .nreset(nreset), .enable(en146), .data_in(din146),
        .commit(cm146),
`ifdef CONFIG_READBACK_EN
        .readback(readback146),
`endif
        .data_out(dout146), .chain_out(chain146), .count(count146), .full(full146),
        .loaded(loaded146), .overflow(ovf146), .commit_err(cerr146)
    );

    typedef struct {
        int           id;
        int unsigned  cyc;
        bit           wide;
        logic [145:0] dout;
        int           cnt;
        logic         full;
        logic         loaded;
        logic         ovf;
        logic         cerr;
        logic [1:0]   chain;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc;
    int          n_vec;
    int          n_err;
    int          n_id;

    logic [145:0] vec146;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input int id, input string what,
                         input logic [145:0] got, input logic [145:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL step%0d %s: got %0h want %0h", id, what, got, want);
        end
    endtask

    // Monitor: compare every expectation due in the cycle just completed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc < cyc) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL step%0d missed: got cycle %0d want cycle %0d", e.id, cyc, e.cyc);
                end else if (e.wide) begin
                    check(e.id, "data_out", dout146, e.dout);
                    check(e.id, "count", 146'(count146), 146'(e.cnt));
                    check(e.id, "full", 146'(full146), 146'(e.full));
                    check(e.id, "loaded", 146'(loaded146), 146'(e.loaded));
                    check(e.id, "overflow", 146'(ovf146), 146'(e.ovf));
                    check(e.id, "commit_err", 146'(cerr146), 146'(e.cerr));
                    check(e.id, "chain_out", 146'(chain146), 146'(e.chain));
                end else begin
                    check(e.id, "data_out", 146'(dout8), e.dout);
                    check(e.id, "count", 146'(count8), 146'(e.cnt));
                    check(e.id, "full", 146'(full8), 146'(e.full));
                    check(e.id, "loaded", 146'(loaded8), 146'(e.loaded));
                    check(e.id, "overflow", 146'(ovf8), 146'(e.ovf));
                    check(e.id, "commit_err", 146'(cerr8), 146'(e.cerr));
                    check(e.id, "chain_out", 146'(chain8), 146'(e.chain));
                end
            end
        end
    end

    // Drive one cycle of 8-bit-chain inputs just after the rising edge.
    task automatic step(input logic nr, input logic en, input logic cm, input logic [1:0] din);
        @(posedge clock);
        #1;
        nreset  = nr;
        enable  = en;
        commit  = cm;
        data_in = din;
        en146   = 1'b0;
        cm146   = 1'b0;
`ifdef CONFIG_READBACK_EN
        readback    = 1'b0;
        readback146 = 1'b0;
`endif
    endtask

    // Expected 8-bit-chain state after the next rising edge.
    task automatic ex(input logic [7:0] dout, input int cnt, input logic f,
                      input logic ld, input logic ov, input logic ce, input logic [1:0] ch);
        exp_t e;
        e.id = n_id; e.cyc = cyc + 1; e.wide = 1'b0; e.dout = 146'(dout);
        e.cnt = cnt; e.full = f; e.loaded = ld; e.ovf = ov; e.cerr = ce; e.chain = ch;
        q.push_back(e);
        n_id++;
    endtask

    task automatic ex146(input logic [145:0] dout, input int cnt, input logic f,
                         input logic ld, input logic ch);
        exp_t e;
        e.id = n_id; e.cyc = cyc + 1; e.wide = 1'b1; e.dout = dout;
        e.cnt = cnt; e.full = f; e.loaded = ld; e.ovf = 1'b0; e.cerr = 1'b0;
        e.chain = {1'b0, ch};
        q.push_back(e);
        n_id++;
    endtask

    initial begin
        cyc = 0; n_vec = 0; n_err = 0; n_id = 0;
        nreset = 1'b0; enable = 1'b0; commit = 1'b0; data_in = 2'b00;
        en146 = 1'b0; din146 = 1'b0; cm146 = 1'b0;
`ifdef CONFIG_READBACK_EN
        readback = 1'b0; readback146 = 1'b0;
`endif
        vec146 = {2'b10, {18{8'hA5}}};

        // Reset with random inputs
        repeat (3) begin
            step(1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
            ex(8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        end

        // Fill and commit
        step(1'b1, 1'b1, 1'b0, 2'b11); ex(8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b00); ex(8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b10); ex(8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b01); ex(8'h00, 4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
        step(1'b1, 1'b0, 1'b1, 2'b00); ex(8'hC9, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);

        // Refill to 0x3C, then simultaneous enable+commit while full
        step(1'b1, 1'b1, 1'b0, 2'b00); ex(8'hC9, 1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b11); ex(8'hC9, 2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
        step(1'b1, 1'b1, 1'b0, 2'b11); ex(8'hC9, 3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
        step(1'b1, 1'b1, 1'b0, 2'b00); ex(8'hC9, 4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b1, 2'b10); ex(8'h3C, 1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);

        // Fill to 0x89, then overflow shift -> 0x26
        step(1'b1, 1'b1, 1'b0, 2'b00); ex(8'h3C, 2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
        step(1'b1, 1'b1, 1'b0, 2'b10); ex(8'h3C, 3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b01); ex(8'h3C, 4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        step(1'b1, 1'b1, 1'b0, 2'b10); ex(8'h3C, 4, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        // Idle holds state
        step(1'b1, 1'b0, 1'b0, 2'b11); ex(8'h3C, 4, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);

        // Reset, then early commit
        step(1'b0, 1'b0, 1'b0, 2'b00); ex(8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b11); ex(8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b00); ex(8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b1, 2'b00); ex(8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b10); ex(8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b01); ex(8'h00, 4, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
        step(1'b1, 1'b0, 1'b1, 2'b00); ex(8'hC9, 0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11);

        // Reset mid-frame, then a clean 0xFF frame
        step(1'b1, 1'b1, 1'b0, 2'b11); ex(8'hC9, 1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b11); ex(8'hC9, 2, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10);
        step(1'b1, 1'b1, 1'b0, 2'b11); ex(8'hC9, 3, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
        step(1'b0, 1'b1, 1'b1, 2'b11); ex(8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b11); ex(8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b11); ex(8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b11); ex(8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b11); ex(8'h00, 4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
        step(1'b1, 1'b0, 1'b1, 2'b00); ex(8'hFF, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
        // Enable+commit while not full: shift, count, commit_err
        step(1'b1, 1'b1, 1'b1, 2'b01); ex(8'hFF, 1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
        step(1'b1, 1'b0, 1'b0, 2'b00); ex(8'hFF, 1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11);

        // Full-width 146-bit frame, MSB first
        for (int i = 0; i < 146; i++) begin
            @(posedge clock);
            #1;
            enable = 1'b0; commit = 1'b0;
            en146  = 1'b1; cm146  = 1'b0;
            din146 = vec146[145 - i];
            if (i == 145) begin
                ex146(146'd0, 146, 1'b1, 1'b0, 1'b1);
            end else begin
                en146 = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        en146 = 1'b0; cm146 = 1'b1;
        ex146(vec146, 0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 2'b00);

`ifdef CONFIG_READBACK_EN
        // Readback of 0xC9 and shift-out on chain_out
        step(1'b0, 1'b0, 1'b0, 2'b00); ex(8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b11);
        step(1'b1, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b10);
        step(1'b1, 1'b1, 1'b0, 2'b01);
        step(1'b1, 1'b0, 1'b1, 2'b00); ex(8'hC9, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
        step(1'b1, 1'b1, 1'b1, 2'b10); readback = 1'b1;
        ex(8'hC9, 4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
        step(1'b1, 1'b1, 1'b0, 2'b00); ex(8'hC9, 4, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b00); ex(8'hC9, 4, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
        step(1'b1, 1'b1, 1'b0, 2'b00); ex(8'hC9, 4, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
        step(1'b1, 1'b0, 1'b0, 2'b00);
`endif

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            @(negedge clock);
        end
        if (q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
